// File: rtl/ps2_key_event_fifo_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ps2_key_event_fifo_if : key-event input and consumer handshake bundle      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface ps2_key_event_fifo_if #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) ();
  logic           key_valid;
  logic [8:0]     last_change;
  logic [511:0]   key_down;
  logic           evt_ready;
  logic           ovf_clr;
  logic           evt_valid;
  logic [9:0]     evt_data;
  logic [CW-1:0]  evt_count;
  logic           overflow;

  modport master (
    output key_valid, last_change, key_down, evt_ready, ovf_clr,
    input  evt_valid, evt_data, evt_count, overflow
  );

  modport slave (
    input  key_valid, last_change, key_down, evt_ready, ovf_clr,
    output evt_valid, evt_data, evt_count, overflow
  );
endinterface
`default_nettype wire

// File: rtl/ps2_key_event_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ps2_key_event_fifo : PS/2 key-state to press/release event FIFO            |
// | Optional: PS2_KEY_EVT_RELEASE_EN enqueues release events as {0,scancode}.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ps2_key_event_fifo #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  wire logic               clk,
  input  wire logic               rst,
  ps2_key_event_fifo_if.slave     bus
);

  localparam int AW = $clog2(DEPTH);
`ifdef PS2_KEY_EVT_RELEASE_EN
  localparam logic REL_EN = 1'b1;
`else
  localparam logic REL_EN = 1'b0;
`endif

  logic [511:0]  held_q, held_d;
  logic [9:0]    mem_q [DEPTH];
  logic [9:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic key_now, key_was;
  logic is_press, is_release, push_req;
  logic full, pop, push, drop;

  always_comb begin
    key_now    = bus.key_down[bus.last_change];
    key_was    = held_q[bus.last_change];
    // Equal states mean a typematic repeat or duplicate strobe: ignored.
    is_press   = bus.key_valid & key_now & ~key_was;
    is_release = bus.key_valid & ~key_now & key_was;
    push_req   = is_press | (REL_EN & is_release);

    full = (count_q == CW'(DEPTH));
    pop  = (count_q != '0) & bus.evt_ready;
    // A same-cycle pop frees the slot, so a full FIFO can still accept.
    push = push_req & (~full | pop);
    drop = push_req & full & ~pop;

    held_d = held_q;
    if (bus.key_valid && (key_now != key_was)) begin
      held_d[bus.last_change] = key_now;
    end

    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = {is_press, bus.last_change};
    end

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);

    if (drop) begin
      overflow_d = 1'b1;
    end else if (bus.ovf_clr) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      held_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      held_q     <= held_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign bus.evt_valid = (count_q != '0);
  assign bus.evt_data  = (count_q != '0) ? mem_q[rd_ptr_q] : 10'h000;
  assign bus.evt_count = count_q;
  assign bus.overflow  = overflow_q;

endmodule
`default_nettype wire
